// File: rtl/pbus_arbiter_if.sv
// Bus bundle for pbus_arbiter: two Wishbone master ports, the slave port and the timeout status.
// The "slave" modport is the arbiter's view; "master" is the view of the surrounding masters and slave.
interface pbus_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic [AW-1:0] M0_ADRi;
    logic [DW-1:0] M0_DATi;
    logic [DW-1:0] M0_DATo;
    logic          M0_WEi;
    logic          M0_CYCi;
    logic          M0_STBi;
    logic          M0_ACKo;
    logic          M0_ERRo;

    logic [AW-1:0] M1_ADRi;
    logic [DW-1:0] M1_DATi;
    logic [DW-1:0] M1_DATo;
    logic          M1_WEi;
    logic          M1_CYCi;
    logic          M1_STBi;
    logic          M1_ACKo;
    logic          M1_ERRo;

    logic [AW-1:0] S_ADRo;
    logic [DW-1:0] S_DATo;
    logic [DW-1:0] S_DATi;
    logic          S_WEo;
    logic          S_CYCo;
    logic          S_STBo;
    logic          S_ACKi;

    logic [1:0]    GNT;
    logic          TMO_FLAG;
    logic [AW-1:0] TMO_ADDR;
    logic          TMO_CLR;

    modport slave (
        input  M0_ADRi, M0_DATi, M0_WEi, M0_CYCi, M0_STBi,
        output M0_DATo, M0_ACKo, M0_ERRo,
        input  M1_ADRi, M1_DATi, M1_WEi, M1_CYCi, M1_STBi,
        output M1_DATo, M1_ACKo, M1_ERRo,
        output S_ADRo, S_DATo, S_WEo, S_CYCo, S_STBo,
        input  S_DATi, S_ACKi,
        output GNT, TMO_FLAG, TMO_ADDR,
        input  TMO_CLR
    );

    modport master (
        output M0_ADRi, M0_DATi, M0_WEi, M0_CYCi, M0_STBi,
        input  M0_DATo, M0_ACKo, M0_ERRo,
        output M1_ADRi, M1_DATi, M1_WEi, M1_CYCi, M1_STBi,
        input  M1_DATo, M1_ACKo, M1_ERRo,
        input  S_ADRo, S_DATo, S_WEo, S_CYCo, S_STBo,
        output S_DATi, S_ACKi,
        input  GNT, TMO_FLAG, TMO_ADDR,
        output TMO_CLR
    );
endinterface

// File: rtl/pbus_arbiter.sv
// Two-master round-robin Wishbone arbiter for the peripheral bus, granting whole CYC tenures.
// Optional beat watchdog (ERR pulse, sticky TMO_FLAG/TMO_ADDR) is built when PBUS_ARB_TIMEOUT_EN is defined.
module pbus_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    pbus_arbiter_if.slave  bus
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("pbus_arbiter: TIMEOUT must lie in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic          last_owner_r;       // 1'b0 = M0 held the last tenure, 1'b1 = M1
    logic          next_last_owner_s;

    logic          own0_s;
    logic          own1_s;
    logic          owner_cyc_s;
    logic          owner_stb_s;
    logic          owner_we_s;
    logic [AW-1:0] owner_adr_s;
    logic [DW-1:0] owner_dat_s;
    logic          err_s;

    // Grant state and round-robin history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
        end else begin
            state_r      <= next_state_s;
            last_owner_r <= next_last_owner_s;
        end
    end

    // Next grant: ties go to the master that did not own the previous tenure
    always_comb begin
        next_state_s      = state_r;
        next_last_owner_s = last_owner_r;
        case (state_r)
            IDLE: begin
                if (bus.M0_CYCi && bus.M1_CYCi) begin
                    next_state_s = last_owner_r ? OWN0 : OWN1;
                end else if (bus.M0_CYCi) begin
                    next_state_s = OWN0;
                end else if (bus.M1_CYCi) begin
                    next_state_s = OWN1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0: begin
                if (!bus.M0_CYCi) begin
                    next_state_s      = IDLE;
                    next_last_owner_s = 1'b0;
                end else begin
                    next_state_s = OWN0;
                end
            end
            OWN1: begin
                if (!bus.M1_CYCi) begin
                    next_state_s      = IDLE;
                    next_last_owner_s = 1'b1;
                end else begin
                    next_state_s = OWN1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Select the owning master's request; everything reads as zero while idle
    always_comb begin
        own0_s      = 1'b0;
        own1_s      = 1'b0;
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
        owner_we_s  = 1'b0;
        owner_adr_s = {AW{1'b0}};
        owner_dat_s = {DW{1'b0}};
        case (state_r)
            OWN0: begin
                own0_s      = 1'b1;
                owner_cyc_s = bus.M0_CYCi;
                owner_stb_s = bus.M0_STBi;
                owner_we_s  = bus.M0_WEi;
                owner_adr_s = bus.M0_ADRi;
                owner_dat_s = bus.M0_DATi;
            end
            OWN1: begin
                own1_s      = 1'b1;
                owner_cyc_s = bus.M1_CYCi;
                owner_stb_s = bus.M1_STBi;
                owner_we_s  = bus.M1_WEi;
                owner_adr_s = bus.M1_ADRi;
                owner_dat_s = bus.M1_DATi;
            end
            default: begin
                own0_s = 1'b0;
                own1_s = 1'b0;
            end
        endcase
    end

    assign bus.GNT    = state_r;
    assign bus.S_CYCo = owner_cyc_s;
    assign bus.S_STBo = owner_stb_s & ~err_s;   // a timed-out beat is withdrawn from the slave
    assign bus.S_WEo  = owner_we_s;
    assign bus.S_ADRo = owner_adr_s;
    assign bus.S_DATo = owner_dat_s;

    assign bus.M0_ACKo = own0_s & bus.M0_STBi & bus.S_ACKi;
    assign bus.M1_ACKo = own1_s & bus.M1_STBi & bus.S_ACKi;
    assign bus.M0_DATo = own0_s ? bus.S_DATi : {DW{1'b0}};
    assign bus.M1_DATo = own1_s ? bus.S_DATi : {DW{1'b0}};
    assign bus.M0_ERRo = own0_s & err_s;
    assign bus.M1_ERRo = own1_s & err_s;

`ifdef PBUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0]    cnt_r;
    logic [7:0]    cnt_next_s;
    logic          tmo_flag_r;
    logic [AW-1:0] tmo_addr_r;

    // Beat watchdog; ACK in the final cycle beats the timeout
    always_comb begin
        err_s = 1'b0;
        if (owner_cyc_s && owner_stb_s && !bus.S_ACKi && (cnt_r == TMO_LAST)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
        if ((next_state_s != state_r) || !(owner_cyc_s && owner_stb_s) || bus.S_ACKi || err_s) begin
            cnt_next_s = 8'd0;
        end else begin
            cnt_next_s = cnt_r + 8'd1;
        end
    end

    // Counter plus sticky timeout record; a new timeout takes priority over TMO_CLR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= 8'd0;
            tmo_flag_r <= 1'b0;
            tmo_addr_r <= {AW{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
            if (err_s) begin
                tmo_flag_r <= 1'b1;
                tmo_addr_r <= owner_adr_s;
            end else if (bus.TMO_CLR) begin
                tmo_flag_r <= 1'b0;
            end else begin
                tmo_flag_r <= tmo_flag_r;
            end
        end
    end

    assign bus.TMO_FLAG = tmo_flag_r;
    assign bus.TMO_ADDR = tmo_addr_r;
`else
    assign err_s        = 1'b0;
    // Without the watchdog there is no flag to clear, so TMO_CLR folds away to a constant 0
    assign bus.TMO_FLAG = bus.TMO_CLR & 1'b0;
    assign bus.TMO_ADDR = {AW{1'b0}};
`endif

endmodule
